// File: rtl/wide_uart_host_pkg.sv
// Shared definitions for the wide-word UART host initiator: FSM state
// encodings, serial line levels and bit-period arithmetic.
package wide_uart_host_pkg;

    // Top-level sequencing states.
    typedef enum logic [3:0] {
        IDLE,
        TX_START,
        TX_DATA,
        TX_STOP,
        RX_WAIT,
        RX_START,
        RX_DATA,
        RX_STOP,
        DONE
    } state_t;

    // Phases of the single-byte receiver.
    typedef enum logic [1:0] {
        RXP_IDLE,
        RXP_START,
        RXP_DATA,
        RXP_STOP
    } rx_phase_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // One bit lasts four quarter-bit periods.
    function automatic int bit_period(input int clock_scale);
        return 4 * clock_scale;
    endfunction

endpackage

// File: rtl/uart_host_rx_byte.sv
// Single-byte 8N1 receiver for the wide UART host. Synchronises rx,
// validates the start bit at mid-start, samples data bits and the stop bit
// at mid-bit, and reports each step as a one-cycle pulse so the top-level
// sequencer can track it. Disabled (i_enable low) it discards everything.
module uart_host_rx_byte
    import wide_uart_host_pkg::*;
#(
    parameter int CLOCK_SCALE = 26
)
(
    input  logic       masterClock,
    input  logic       reset,
    input  logic       i_rx,
    input  logic       i_enable,
    output logic       o_start_edge,
    output logic       o_glitch,
    output logic       o_start_ok,
    output logic       o_data_done,
    output logic       o_valid,
    output logic       o_stop_error,
    output logic [7:0] o_byte
);

    localparam int BIT_PERIOD  = bit_period(CLOCK_SCALE);
    localparam int HALF_PERIOD = BIT_PERIOD / 2;
    localparam int CNT_W       = $clog2(BIT_PERIOD);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    rx_phase_t        r_phase;
    rx_phase_t        w_phase_next;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             w_half_end;
    logic             w_bit_end;

    assign w_half_end = (r_cnt == CNT_W'(HALF_PERIOD - 1));
    assign w_bit_end  = (r_cnt == CNT_W'(BIT_PERIOD - 1));
    assign o_byte     = r_shift;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge masterClock or posedge reset) begin
        // NOTE: flops take non-blocking assignments so every register in the
        // chain samples its old neighbour value on the same edge.
        if (reset) begin
            r_sync1   <= IDLE_LEVEL;
            r_sync2   <= IDLE_LEVEL;
            r_rx_prev <= IDLE_LEVEL;
        end else begin
            r_sync1   <= i_rx;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    // Receiver phase register.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_phase <= RXP_IDLE;
        end else begin
            r_phase <= w_phase_next;
        end
    end

    // Next phase and event pulses; rx is only looked at while enabled.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_phase_next = r_phase;
        o_start_edge = 1'b0;
        o_glitch     = 1'b0;
        o_start_ok   = 1'b0;
        o_data_done  = 1'b0;
        o_valid      = 1'b0;
        o_stop_error = 1'b0;
        if (!i_enable) begin
            w_phase_next = RXP_IDLE;
        end else begin
            case (r_phase)
                RXP_IDLE: begin
                    if (r_rx_prev == IDLE_LEVEL && r_sync2 == START_BIT) begin
                        o_start_edge = 1'b1;
                        w_phase_next = RXP_START;
                    end
                end
                RXP_START: begin
                    if (w_half_end) begin
                        if (r_sync2 == START_BIT) begin
                            o_start_ok   = 1'b1;
                            w_phase_next = RXP_DATA;
                        end else begin
                            o_glitch     = 1'b1;
                            w_phase_next = RXP_IDLE;
                        end
                    end
                end
                RXP_DATA: begin
                    if (w_bit_end && r_bit_idx == 3'd7) begin
                        o_data_done  = 1'b1;
                        w_phase_next = RXP_STOP;
                    end
                end
                RXP_STOP: begin
                    if (w_bit_end) begin
                        o_valid      = (r_sync2 == STOP_BIT);
                        o_stop_error = (r_sync2 != STOP_BIT);
                        w_phase_next = RXP_IDLE;
                    end
                end
                default: w_phase_next = RXP_IDLE;
            endcase
        end
    end

    // Bit timing counter, data bit index and LSB-first shift register.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            if (r_phase == RXP_IDLE || r_phase != w_phase_next || w_bit_end) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (r_phase == RXP_START) begin
                r_bit_idx <= '0;
            end else if (r_phase == RXP_DATA && w_bit_end) begin
                r_bit_idx <= r_bit_idx + 3'd1;
                r_shift   <= {r_sync2, r_shift[7:1]};
            end
        end
    end

endmodule

// File: rtl/wide_uart_host.sv
// Wide-word UART host initiator. On a start pulse it sends a control byte
// followed by WIDTH payload bytes (MSB byte first, 8N1, LSB first), then
// collects a WIDTH-byte response and presents it as one word with a strobe.
// Optional build macro WIDE_UART_HOST_TIMEOUT_EN adds a response timeout
// (TIMEOUT_BITS bit periods) and the timeout output.
module wide_uart_host
    import wide_uart_host_pkg::*;
#(
    parameter int CLOCK_SCALE  = 26,
    parameter int WIDTH        = 4
`ifdef WIDE_UART_HOST_TIMEOUT_EN
    ,
    parameter int TIMEOUT_BITS = 200
`endif
)
(
    input  logic                 masterClock,
    input  logic                 reset,
    input  logic                 rx,
    output logic                 tx,
    input  logic [7:0]           control,
    input  logic [8*WIDTH-1:0]   outputData,
    input  logic                 start,
    output logic                 busy,
    output logic [8*WIDTH-1:0]   responseData,
    output logic                 responseValid,
    output logic                 frameError
`ifdef WIDE_UART_HOST_TIMEOUT_EN
    ,
    output logic                 timeout
`endif
);

    localparam int BIT_PERIOD = bit_period(CLOCK_SCALE);
    localparam int BIT_CNT_W  = $clog2(BIT_PERIOD);
    localparam int BYTE_CNT_W = $clog2(WIDTH + 2);

    state_t                r_state;
    state_t                w_state_next;
    logic [BIT_CNT_W-1:0]  r_bit_cnt;
    logic [2:0]            r_bit_idx;
    logic [BYTE_CNT_W-1:0] r_byte_cnt;
    logic [7:0]            r_tx_shift;
    logic [8*WIDTH-1:0]    r_payload;
    logic                  r_tx;
    logic [8*WIDTH-1:0]    r_resp_shift;
    logic [8*WIDTH-1:0]    r_response_data;
    logic                  r_response_valid;
    logic                  r_frame_error;

    logic                  w_bit_end;
    logic                  w_in_tx;
    logic                  w_rx_enable;
    logic                  w_last_tx_byte;
    logic                  w_last_rx_byte;
    logic                  w_frame_ok;
    logic                  w_frame_bad;
    logic [8*WIDTH-1:0]    w_resp_word;
    logic                  w_timeout_hit;

    logic                  w_rx_start_edge;
    logic                  w_rx_glitch;
    logic                  w_rx_start_ok;
    logic                  w_rx_data_done;
    logic                  w_rx_byte_ok;
    logic                  w_rx_stop_err;
    logic [7:0]            w_rx_byte;

    assign w_bit_end      = (r_bit_cnt == BIT_CNT_W'(BIT_PERIOD - 1));
    assign w_in_tx        = (r_state == TX_START) || (r_state == TX_DATA) ||
                            (r_state == TX_STOP);
    assign w_rx_enable    = (r_state == RX_WAIT) || (r_state == RX_START) ||
                            (r_state == RX_DATA) || (r_state == RX_STOP);
    assign w_last_tx_byte = (r_byte_cnt == BYTE_CNT_W'(WIDTH));
    assign w_last_rx_byte = (r_byte_cnt == BYTE_CNT_W'(WIDTH - 1));
    assign w_resp_word    = (r_resp_shift << 8) | (8*WIDTH)'(w_rx_byte);
    assign w_frame_ok     = (r_state == RX_STOP) && w_rx_byte_ok && w_last_rx_byte;
    assign w_frame_bad    = (r_state == RX_STOP) && w_rx_stop_err;

    assign tx            = r_tx;
    assign busy          = (r_state != IDLE) && (r_state != DONE);
    assign responseData  = r_response_data;
    assign responseValid = r_response_valid;
    assign frameError    = r_frame_error;

    uart_host_rx_byte #(
        .CLOCK_SCALE (CLOCK_SCALE)
    ) u_rx_byte (
        .masterClock  (masterClock),
        .reset        (reset),
        .i_rx         (rx),
        .i_enable     (w_rx_enable),
        .o_start_edge (w_rx_start_edge),
        .o_glitch     (w_rx_glitch),
        .o_start_ok   (w_rx_start_ok),
        .o_data_done  (w_rx_data_done),
        .o_valid      (w_rx_byte_ok),
        .o_stop_error (w_rx_stop_err),
        .o_byte       (w_rx_byte)
    );

`ifdef WIDE_UART_HOST_TIMEOUT_EN
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * BIT_PERIOD;
    localparam int TMR_W          = $clog2(TIMEOUT_CYCLES);

    logic [TMR_W-1:0] r_timer;
    logic             r_timeout;

    assign w_timeout_hit = (r_state == RX_WAIT) && !w_rx_start_edge &&
                           (r_timer == TMR_W'(TIMEOUT_CYCLES - 1));
    assign timeout       = r_timeout;

    // Counts idle cycles while waiting for a response start bit.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_timer   <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= w_timeout_hit;
            if (r_state != RX_WAIT || w_state_next != RX_WAIT) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:     if (start) w_state_next = TX_START;
            TX_START: if (w_bit_end) w_state_next = TX_DATA;
            TX_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_state_next = TX_STOP;
            TX_STOP: begin
                if (w_bit_end) begin
                    w_state_next = w_last_tx_byte ? RX_WAIT : TX_START;
                end
            end
            RX_WAIT: begin
                if (w_rx_start_edge) begin
                    w_state_next = RX_START;
                end else if (w_timeout_hit) begin
                    w_state_next = DONE;
                end
            end
            RX_START: begin
                if (w_rx_start_ok) begin
                    w_state_next = RX_DATA;
                end else if (w_rx_glitch) begin
                    w_state_next = RX_WAIT;
                end
            end
            RX_DATA:  if (w_rx_data_done) w_state_next = RX_STOP;
            RX_STOP: begin
                if (w_rx_byte_ok) begin
                    w_state_next = w_last_rx_byte ? DONE : RX_WAIT;
                end else if (w_rx_stop_err) begin
                    w_state_next = DONE;
                end
            end
            DONE:     w_state_next = IDLE;
            default:  w_state_next = IDLE;
        endcase
    end

    // Bit period counter for the transmit side.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_bit_cnt <= '0;
        end else if (!w_in_tx || w_bit_end || r_state != w_state_next) begin
            r_bit_cnt <= '0;
        end else begin
            r_bit_cnt <= r_bit_cnt + BIT_CNT_W'(1);
        end
    end

    // Transmit shifter, byte sequencing and response word assembly.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_tx         <= IDLE_LEVEL;
            r_tx_shift   <= '0;
            r_payload    <= '0;
            r_bit_idx    <= '0;
            r_byte_cnt   <= '0;
            r_resp_shift <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_tx_shift <= control;
                        r_payload  <= outputData;
                        r_tx       <= START_BIT;
                        r_byte_cnt <= '0;
                    end
                end
                TX_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_tx_shift[0];
                        r_bit_idx <= '0;
                    end
                end
                TX_DATA: begin
                    if (w_bit_end) begin
                        r_bit_idx  <= r_bit_idx + 3'd1;
                        r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                        r_tx       <= (r_bit_idx == 3'd7) ? STOP_BIT : r_tx_shift[1];
                    end
                end
                TX_STOP: begin
                    if (w_bit_end) begin
                        if (w_last_tx_byte) begin
                            r_tx       <= IDLE_LEVEL;
                            r_byte_cnt <= '0;
                        end else begin
                            r_tx       <= START_BIT;
                            r_tx_shift <= r_payload[8*WIDTH-1 -: 8];
                            r_payload  <= r_payload << 8;
                            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
                        end
                    end
                end
                RX_STOP: begin
                    if (w_rx_byte_ok) begin
                        r_resp_shift <= w_resp_word;
                        if (!w_last_rx_byte) begin
                            r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Completion strobes and the published response word.
    always_ff @(posedge masterClock or posedge reset) begin
        if (reset) begin
            r_response_data  <= '0;
            r_response_valid <= 1'b0;
            r_frame_error    <= 1'b0;
        end else begin
            r_response_valid <= w_frame_ok;
            r_frame_error    <= w_frame_bad;
            if (w_frame_ok) begin
                r_response_data <= w_resp_word;
            end
        end
    end

endmodule

// File: tb/tb_wide_uart_host.sv
// Directed bench for wide_uart_host: table of command/reply vectors plus
// hand-written reset-mid-frame and (with WIDE_UART_HOST_TIMEOUT_EN) timeout
// sequences.
module tb_wide_uart_host;

    localparam int CS      = 26;
    localparam int W       = 4;
    localparam int BIT     = 4 * CS;
    localparam int FRAME   = (W + 1) * 10 * BIT;
    localparam int LOG_LEN = FRAME + 100;
`ifdef WIDE_UART_HOST_TIMEOUT_EN
    localparam int TO_BITS = 200;
`endif

    logic        clk;
    logic        reset;
    logic        rx;
    logic        tx;
    logic [7:0]  control;
    logic [31:0] outputData;
    logic        start;
    logic        busy;
    logic [31:0] responseData;
    logic        responseValid;
    logic        frameError;
`ifdef WIDE_UART_HOST_TIMEOUT_EN
    logic        timeout;
`endif

    wide_uart_host #(
        .CLOCK_SCALE (CS),
        .WIDTH       (W)
`ifdef WIDE_UART_HOST_TIMEOUT_EN
        ,
        .TIMEOUT_BITS (TO_BITS)
`endif
    ) dut (
        .masterClock   (clk),
        .reset         (reset),
        .rx            (rx),
        .tx            (tx),
        .control       (control),
        .outputData    (outputData),
        .start         (start),
        .busy          (busy),
        .responseData  (responseData),
        .responseValid (responseValid),
        .frameError    (frameError)
`ifdef WIDE_UART_HOST_TIMEOUT_EN
        ,
        .timeout       (timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  ctl;
        logic [31:0] data;
        int          poke;       // log cycle at which start is re-pulsed (-1: never)
        logic [31:0] reply;
        logic [3:0]  bad_stop;   // bit i set: reply byte i gets stop=0
        bit          glitch;
        int          exp_valid;
        int          exp_fe;
        logic [31:0] exp_resp;
    } vec_t;

    int   n_vec  = 0;
    int   n_miss = 0;
    logic tx_log   [LOG_LEN];
    logic busy_log [LOG_LEN];
    vec_t vecs [4];
    vec_t rv;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic [7:0] ctl, input logic [31:0] data, input int poke,
                                input logic [31:0] reply, input logic [3:0] bad, input bit glitch,
                                input int ev, input int ef, input logic [31:0] er);
        vec_t v;
        v.ctl = ctl; v.data = data; v.poke = poke; v.reply = reply; v.bad_stop = bad;
        v.glitch = glitch; v.exp_valid = ev; v.exp_fe = ef; v.exp_resp = er;
        return v;
    endfunction

    // Issue a command, record tx/busy for the whole frame, then check every
    // cycle of every bit against the expected 8N1 waveform.
    task automatic send_and_log(input logic [7:0] ctl, input logic [31:0] data, input int poke);
        logic [39:0] frame;
        logic [7:0]  b_val;
        logic        exp_bit;
        int          errs;
        frame      = {ctl, data};
        control    = ctl;
        outputData = data;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        for (int c = 0; c < LOG_LEN; c++) begin
            tx_log[c]   = tx;
            busy_log[c] = busy;
            if (c == poke) begin
                control    = ~ctl;
                outputData = ~data;
                start      = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        for (int b = 0; b <= W; b++) begin
            b_val = frame[39 - 8*b -: 8];
            errs  = 0;
            for (int k = 0; k < 10; k++) begin
                exp_bit = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b_val[k-1];
                for (int j = 0; j < BIT; j++) begin
                    if (tx_log[(b*10 + k)*BIT + j] !== exp_bit) errs++;
                end
            end
            check($sformatf("tx byte %0d (0x%0h) bad cycles", b, b_val), errs, 0);
        end
        errs = 0;
        for (int c = 0; c < FRAME; c++) if (busy_log[c] !== 1'b1) errs++;
        check("busy low cycles during command", errs, 0);
        errs = 0;
        for (int c = FRAME; c < LOG_LEN; c++) if (tx_log[c] !== 1'b1) errs++;
        check("tx not idle after command", errs, 0);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (BIT) tick();
        for (int k = 0; k < 8; k++) begin
            rx = b[k];
            repeat (BIT) tick();
        end
        rx = stop_bit;
        repeat (BIT) tick();
        rx = 1'b1;
    endtask

    task automatic run_vector(input vec_t v, input int idx);
        int n_valid;
        int n_fe;
        int strobe_at;
        int fall_at;
        logic busy_after;
        logic prev_busy;
        send_and_log(v.ctl, v.data, v.poke);
        repeat (200) tick();
        if (v.glitch) begin
            rx = 1'b0;
            repeat (20) tick();
            rx = 1'b1;
            repeat (200) tick();
        end
        n_valid    = 0;
        n_fe       = 0;
        strobe_at  = -1;
        fall_at    = -1;
        busy_after = 1'b0;
        fork
            begin
                for (int i = 0; i < W; i++) send_byte(v.reply[31 - 8*i -: 8], !v.bad_stop[i]);
            end
            begin
                prev_busy = busy;
                for (int c = 0; c < W*10*BIT + 400; c++) begin
                    tick();
                    if (responseValid) begin n_valid++; strobe_at = c; end
                    if (frameError)    begin n_fe++;    strobe_at = c; end
                    if (prev_busy && !busy && fall_at < 0) begin
                        fall_at = c;
                        start   = 1'b1;
                    end else if (fall_at >= 0 && c == fall_at + 1) begin
                        start      = 1'b0;
                        busy_after = busy;
                    end
                    prev_busy = busy;
                end
            end
        join
        check($sformatf("v%0d responseValid cycles", idx), n_valid, v.exp_valid);
        check($sformatf("v%0d frameError cycles", idx), n_fe, v.exp_fe);
        check($sformatf("v%0d responseData", idx), responseData, v.exp_resp);
        check($sformatf("v%0d busy after frame", idx), busy, 0);
        check($sformatf("v%0d busy fall vs strobe cycle", idx), fall_at, strobe_at);
        check($sformatf("v%0d start at busy fall accepted", idx), busy_after, 0);
    endtask

    initial begin
        reset      = 1'b1;
        rx         = 1'b1;
        start      = 1'b0;
        control    = '0;
        outputData = '0;
        repeat (3) tick();
        check("reset tx", tx, 1);
        check("reset busy", busy, 0);
        check("reset responseData", responseData, 0);
        check("reset responseValid", responseValid, 0);
        check("reset frameError", frameError, 0);
`ifdef WIDE_UART_HOST_TIMEOUT_EN
        check("reset timeout", timeout, 0);
`endif
        reset = 1'b0;
        tick();

        vecs[0] = mk(8'hA5, 32'h12345678, -1,   32'hDEADBEEF, 4'b0000, 1'b0, 1, 0, 32'hDEADBEEF);
        vecs[1] = mk(8'h3C, 32'h0F1E2D4B, -1,   32'h01234567, 4'b0100, 1'b0, 0, 1, 32'hDEADBEEF);
        vecs[2] = mk(8'h81, 32'hCAFE0001, 1500, 32'hA55A0FF0, 4'b0000, 1'b1, 1, 0, 32'hA55A0FF0);
        vecs[3] = mk(8'h00, 32'hFFFFFFFF, -1,   32'h00FF807F, 4'b0000, 1'b0, 1, 0, 32'h00FF807F);
        for (int i = 0; i < 4; i++) run_vector(vecs[i], i);

        // Reset during data bit 3 of the second byte (payload MSB byte 0x00).
        control    = 8'h5A;
        outputData = 32'h00FF00FF;
        start      = 1'b1;
        tick();
        start = 1'b0;
        repeat (14*BIT + BIT/2) tick();
        check("tx low before mid-frame reset", tx, 0);
        reset = 1'b1;
        #1;
        check("tx during mid-frame reset", tx, 1);
        check("busy during mid-frame reset", busy, 0);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rv = mk(8'h5A, 32'h00FF00FF, -1, 32'h13579BDF, 4'b0000, 1'b0, 1, 0, 32'h13579BDF);
        run_vector(rv, 4);

`ifdef WIDE_UART_HOST_TIMEOUT_EN
        begin
            int   seen;
            int   idx;
            logic busy_at;
            send_and_log(8'h11, 32'h22334455, -1);
            idx     = LOG_LEN;
            seen    = -1;
            busy_at = 1'b1;
            for (int c = 0; c < 22000 && seen < 0; c++) begin
                if (timeout) begin
                    seen    = idx;
                    busy_at = busy;
                end else begin
                    tick();
                    idx++;
                end
            end
            check("timeout cycle after tx fall", seen, FRAME + TO_BITS*BIT);
            check("busy at timeout", busy_at, 0);
            tick();
            check("timeout single cycle", timeout, 0);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wide_uart_host.md
Name: wide_uart_host

Overview:
- Host-side initiator for the wide-word UART protocol spoken by the board's data interface. Lets one FPGA drive another board's sandbox, or loop back its own, without a PC.
- On a start pulse, serialises one command frame (control byte followed by WIDTH data bytes) on tx. It then collects the WIDTH-byte response frame from rx and presents it as one wide word with a valid strobe.
- Sits beside the sandbox process logic as a self-test master.

Parameters:
- CLOCK_SCALE, 26, quarter-bit period in masterClock cycles; bit period = 4*CLOCK_SCALE (104 clocks = 115200 baud at 12 MHz).
- WIDTH, 4, number of data bytes per frame; data words are 8*WIDTH bits.
- TIMEOUT_BITS, 200, response timeout in bit periods (used only with the optional feature).

Ports:
- masterClock  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- rx  input  1  serial in, asynchronous to masterClock, idle high.
- tx  output  1  serial out, idle high.
- control  input  8  control byte for the command frame.
- outputData  input  8*WIDTH  command payload.
- start  input  1  single-cycle request.
- busy  output  1  high from accept until response or error.
- responseData  output  8*WIDTH  last received response word.
- responseValid  output  1  one-cycle strobe when responseData updates.
- frameError  output  1  one-cycle strobe on a bad stop bit.

Behaviour:
- Reset values: tx=1, busy=0, responseData=0, responseValid=0, frameError=0. FSM goes to IDLE.
- Line format: 8N1, LSB first. Bytes are sent MSB byte first: control, then outputData[8W-1:8W-8], and so on down to [7:0].
- Accepting a request:
  - start is sampled in IDLE only; start while busy is ignored with no queuing.
  - On accept at cycle N, control and outputData are latched. busy=1 from N+1 and tx falls at N+1.
- Each bit is held exactly 4*CLOCK_SCALE cycles. There is no idle gap between bytes: the next start bit immediately follows the stop bit.
- FSM states: IDLE -> TX_START -> TX_DATA(8) -> TX_STOP -> (next byte, or RX_WAIT after byte WIDTH+1) -> RX_START -> RX_DATA(8) -> RX_STOP -> (next byte, or DONE) -> IDLE.
- Receive synchronisation and start detection:
  - rx passes through a two-flop synchroniser.
  - rx is ignored outside the RX_* states, so echo and noise during transmit are discarded.
  - A falling edge in RX_WAIT starts the count. rx is re-checked at mid-start (2*CLOCK_SCALE). If it is high, the event is a glitch and the FSM returns to RX_WAIT.
- Receive sampling: data bits are sampled at mid-bit. The stop bit is sampled at mid-stop. Received bytes shift into the response word MSB byte first.
- Completion:
  - If stop=1 on the last byte, responseData updates and responseValid pulses in the cycle after the final stop sample. busy falls in that same cycle.
  - If stop=0 on any byte, frameError pulses, the remaining bytes are abandoned, responseData is unchanged and busy falls.
- start in the cycle busy falls is ignored; the earliest new accept is the following cycle.
- Reset mid-frame: tx goes high immediately (asynchronously) and all partial state is discarded.
- Counter widths: bit counter is clog2(4*CLOCK_SCALE); byte counter is clog2(WIDTH+2).

Optional Feature:
- Macro: WIDE_UART_HOST_TIMEOUT_EN.
- With it defined:
  - An added output timeout (1 bit, reset 0) pulses one cycle if no start edge arrives within TIMEOUT_BITS bit periods in RX_WAIT, or between response bytes.
  - busy then falls and the FSM returns to IDLE.
- Without it: RX_WAIT waits indefinitely, and the timeout port and counter do not exist.

Decomposition:
- Shared package holds:
  - FSM state encoding typedef.
  - Line constants: START_BIT=0, STOP_BIT=1, IDLE_LEVEL=1.
  - Function computing bit period = 4*CLOCK_SCALE.
- One natural sub-module: uart_host_rx_byte. It owns the synchroniser, start validation and mid-bit sampling, and reports byte/valid/stopError. The top owns the TX shifter, byte sequencing and response assembly.

Test Plan:
- Basic command frame: WIDTH=4, CLOCK_SCALE=26; start with control=0xA5, outputData=0x12345678 -> tx carries A5,12,34,56,78 at 104 clocks/bit, exactly 5200 clocks from the tx fall to the end of the last stop bit; busy=1 throughout.
- Normal response: bench replies 0xDE,0xAD,0xBE,0xEF 300 clocks after the command ends -> responseData=0xDEADBEEF, responseValid high exactly one cycle, busy falls the same cycle.
- Framing error: reply whose third byte has stop=0 -> frameError pulses once, responseData keeps its previous value, busy=0, no responseValid.
- Start while busy and rx glitch: start re-pulsed mid-transmit -> ignored, tx stream unchanged. A 20-clock low glitch on rx in RX_WAIT -> rejected, and the next valid reply is still received.
- Reset mid-frame: assert reset during data bit 3 of the second byte -> tx=1 and busy=0 immediately. A fresh start afterwards yields a complete, correct frame.
- Timeout (macro defined, TIMEOUT_BITS=200): no reply -> timeout pulses at 200*104 clocks after the command ends, and busy falls.
